// File: rtl/volume_ramp.sv
// volume_ramp: zipper-free master volume for 24-bit stereo pairs.
// Applied Q1.15 gain slews toward the effective target by STEP_Q15 per accepted pair.
module volume_ramp #(
    parameter int STEP_Q15 = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [23:0] in_l,
    input  logic [23:0] in_r,
    input  logic [15:0] target_q15,
    input  logic        mute,
    output logic        out_valid,
    output logic [23:0] out_l,
    output logic [23:0] out_r,
    output logic [15:0] gain_q15,
    output logic        ramping,
    output logic        muted
);

    typedef enum logic [1:0] {
        S_MUTED,
        S_STEADY,
        S_RAMP_UP,
        S_RAMP_DOWN
    } state_t;

    localparam logic [16:0] STEP = 17'(STEP_Q15);

    state_t      r_state;
    logic [14:0] r_gain;
    logic        r_out_valid;
    logic [23:0] r_out_l;
    logic [23:0] r_out_r;

    logic [14:0] w_t;
    logic [16:0] w_g17;
    logic [16:0] w_t17;
    logic [16:0] w_up;
    logic [16:0] w_lo;
    logic [14:0] w_step_gain;
    logic [14:0] w_g_next;

    logic signed [39:0] w_xl;
    logic signed [39:0] w_xr;
    logic signed [39:0] w_gx;
    logic signed [39:0] w_prod_l;
    logic signed [39:0] w_prod_r;
    logic               w_unused;

    assign w_t   = mute ? 15'd0 :
                   (target_q15[15] ? 15'h7FFF : target_q15[14:0]);
    assign w_g17 = {2'b00, r_gain};
    assign w_t17 = {2'b00, w_t};
    assign w_up  = w_g17 + STEP;
    assign w_lo  = w_t17 + STEP;

    // 17-bit compares so neither direction can wrap past the target
    always_comb begin
        w_step_gain = r_gain;
        if (w_g17 < w_t17) begin
            w_step_gain = (w_up >= w_t17) ? w_t : w_up[14:0];
        end else if (w_g17 > w_t17) begin
            w_step_gain = (w_g17 >= w_lo) ? 15'(w_g17 - STEP) : w_t;
        end
    end

    assign w_g_next = in_valid ? w_step_gain : r_gain;

    assign w_xl     = {{16{in_l[23]}}, in_l};
    assign w_xr     = {{16{in_r[23]}}, in_r};
    assign w_gx     = {25'd0, r_gain};
    assign w_prod_l = w_xl * w_gx;
    assign w_prod_r = w_xr * w_gx;

    assign w_unused = ^{w_prod_l[39], w_prod_l[14:0],
                        w_prod_r[39], w_prod_r[14:0], w_up[16:15]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gain      <= '0;
            r_out_valid <= 1'b0;
            r_out_l     <= '0;
            r_out_r     <= '0;
        end else begin
            r_out_valid <= in_valid;
            r_gain      <= w_g_next;
            if (in_valid) begin
                r_out_l <= w_prod_l[38:15];
                r_out_r <= w_prod_r[38:15];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_MUTED;
        end else if (w_g_next == w_t) begin
            r_state <= (w_t == 15'd0) ? S_MUTED : S_STEADY;
        end else if (w_g_next < w_t) begin
            r_state <= S_RAMP_UP;
        end else begin
            r_state <= S_RAMP_DOWN;
        end
    end

    assign out_valid = r_out_valid;
    assign out_l     = r_out_l;
    assign out_r     = r_out_r;
    assign gain_q15  = {1'b0, r_gain};
    assign ramping   = (r_state == S_RAMP_UP) || (r_state == S_RAMP_DOWN);
    assign muted     = (r_state == S_MUTED);

endmodule

// File: doc/volume_ramp.md
# volume_ramp

Zipper-free master volume stage sitting directly upstream of the balance/crossfeed stage. Applies a Q1.15 gain to each 24-bit stereo sample pair and moves the applied gain toward the requested target by a fixed step per accepted sample, so that volume changes and mute produce linear fades instead of steps. After reset it fades in from silence. Output feeds the balance/crossfeed stage's valid/L/R inputs directly.

## Interface
- STEP_Q15, 64, gain change per accepted sample in Q1.15 LSBs; legal range 1..32767 (64 gives a 512-sample full-scale fade)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample-pair strobe; one pair per high cycle
- in_l  in  24  left sample, two's complement
- in_r  in  24  right sample, two's complement
- target_q15  in  16  requested gain, unsigned Q1.15; values above 32767 clamp to 32767
- mute  in  1  level: when high, effective target is 0
- out_valid  out  1  in_valid delayed one cycle
- out_l  out  24  scaled left sample, two's complement
- out_r  out  24  scaled right sample, two's complement
- gain_q15  out  16  currently applied gain register (bit 15 always 0)
- ramping  out  1  high in RAMP_UP or RAMP_DOWN
- muted  out  1  high in MUTED

## Operation
- Effective target t = mute ? 0 : min(target_q15, 32767); sampled every cycle, no latching.
- Gain register g, 15-bit magnitude, 0..32767.
- On a cycle with in_valid=1:
  - out_l <= (sext(in_l) * g) >>> 15, same for out_r, using g before update; 40-bit signed product, arithmetic shift (floor toward -inf), low 24 bits kept. No overflow possible since g ≤ 32767.
  - g update: g < t -> g <= min(g + STEP_Q15, t); g > t -> g <= max(g - STEP_Q15, t); g == t -> unchanged. Compare/add at 17 bits, no wrap.
- On in_valid=0: g, out_l, out_r hold; only state/status may change.
- FSM, registered, next state computed every cycle from g_next (g after this cycle's update) and current t:
  - MUTED: g_next == 0 and t == 0.
  - STEADY: g_next == t and t != 0.
  - RAMP_UP: g_next < t.
  - RAMP_DOWN: g_next > t.
- Direction reversal: if t crosses g mid-ramp, next state flips immediately; gain moves the new direction on the next accepted sample.
- mute deassertion from MUTED -> RAMP_UP toward target_q15; target 0 with mute low is reported as MUTED.

## Timing
- Reset values: out_valid=0, out_l=0, out_r=0, g=0 (gain_q15=0), state=MUTED (muted=1, ramping=0).
- rst mid-ramp wins over in_valid in same cycle: next cycle all reset values, in-flight sample dropped.
- Latency: 1 cycle in_valid -> out_valid; fully pipelined, accepts a pair every cycle; no backpressure.
- gain_q15 / ramping / muted reflect state after the edge; ramping/muted lag a t change by exactly 1 cycle even with in_valid low.
- Fade length from g0 to t: ceil(|t - g0| / STEP_Q15) accepted samples; last step clamps exactly to t.

## Test plan
- Fade-in: rst 1 cycle, target=32767, mute=0, in_valid every cycle, in_l=in_r=0x100000 -> first out_l=0x000000, second 0x000800; gain_q15=32767 after 512 samples, ramping falls, state STEADY; gain never exceeds 32767.
- Full scale steady: g=32767, in_l=0x7FFFFF, in_r=0x800000 -> out_l=0x7FFEFF, out_r=0x800100, out_valid one cycle after in_valid.
- Mute mid-ramp: at g=1000 assert mute -> ramping stays 1, g decreases 64 per sample, reaches 0 after 16 samples, muted=1 next edge, outputs 0; release mute -> RAMP_UP.
- Valid gaps: in_valid 1,0,0,1 -> g changes only on the two valid cycles, out_l/out_r hold during gaps, out_valid mirrors delayed pattern.
- Reversal and clamp: ramping up at g=20000, set target_q15=0x9000 (clamps 32767) then 10000 -> ramping continues up then RAMP_DOWN next cycle, settles g=10000 exactly, STEADY.
- Reset mid-ramp with in_valid high -> next cycle out_valid=0, outputs 0, gain_q15=0, muted=1.
